core_mem_bridge: RTL and testbench



---
 rtl/core_mem_bridge_if.sv | 45 ++++
 rtl/core_mem_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_core_mem_bridge.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_bridge_if.sv
// AXI4-Lite channel bundle between the core data-memory bridge and the interconnect.
// The master modport is the bridge side; the slave modport is the interconnect side.
interface core_mem_bridge_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
);
    logic              m_awvalid;
    logic              m_awready;
    logic [ADDR_W-1:0] m_awaddr;

    logic              m_wvalid;
    logic              m_wready;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;

    logic              m_bvalid;
    logic              m_bready;
    logic [1:0]        m_bresp;

    logic              m_arvalid;
    logic              m_arready;
    logic [ADDR_W-1:0] m_araddr;

    logic              m_rvalid;
    logic              m_rready;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;

    modport master (
        output m_awvalid, m_awaddr, input m_awready,
        output m_wvalid, m_wdata, m_wstrb, input m_wready,
        input m_bvalid, m_bresp, output m_bready,
        output m_arvalid, m_araddr, input m_arready,
        input m_rvalid, m_rdata, m_rresp, output m_rready
    );

    modport slave (
        input m_awvalid, m_awaddr, output m_awready,
        input m_wvalid, m_wdata, m_wstrb, output m_wready,
        output m_bvalid, m_bresp, input m_bready,
        input m_arvalid, m_araddr, output m_arready,
        output m_rvalid, m_rdata, m_rresp, input m_rready
    );
endinterface

// File: rtl/core_mem_bridge.sv
// Converts the core's single-beat data-memory requests into AXI4-Lite transactions, stalling the core until done.
// Optional performance counters are built when CORE_MEM_BRIDGE_PERF_EN is defined.
module core_mem_bridge #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rd_en_i,
    input  logic              mem_wr_en_i,
    input  logic [ADDR_W-1:0] addr_mem_rd_i,
    input  logic [ADDR_W-1:0] addr_mem_wr_i,
    input  logic [DATA_W-1:0] data_mem_wr_i,
    input  logic [STRB_W-1:0] strb_mem_wr_i,
    output logic [DATA_W-1:0] data_mem_o,
    output logic              stall_mem_o,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] err_addr_o,
`ifdef CORE_MEM_BRIDGE_PERF_EN
    output logic [31:0]       perf_rd_cnt_o,
    output logic [31:0]       perf_wr_cnt_o,
    output logic [31:0]       perf_stall_cnt_o,
`endif
    core_mem_bridge_if.master axi
);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t state;

    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic aw_done;
    logic w_done;
    logic pend_rd;
    logic err_seen;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic b_err;
    logic r_err;

    assign aw_hs = awvalid_q & axi.m_awready;
    assign w_hs  = wvalid_q & axi.m_wready;
    assign b_hs  = bready_q & axi.m_bvalid;
    assign ar_hs = arvalid_q & axi.m_arready;
    assign r_hs  = rready_q & axi.m_rvalid;
    assign b_err = axi.m_bresp != RESP_OKAY;
    assign r_err = axi.m_rresp != RESP_OKAY;

    assign axi.m_awvalid = awvalid_q;
    assign axi.m_awaddr  = awaddr_q;
    assign axi.m_wvalid  = wvalid_q;
    assign axi.m_wdata   = wdata_q;
    assign axi.m_wstrb   = wstrb_q;
    assign axi.m_bready  = bready_q;
    assign axi.m_arvalid = arvalid_q;
    assign axi.m_araddr  = araddr_q;
    assign axi.m_rready  = rready_q;

    // The stall is released only in DONE so the core advances on exactly one edge per request.
    always_comb begin
        unique case (state)
            S_IDLE:  stall_mem_o = mem_rd_en_i | mem_wr_en_i;
            S_DONE:  stall_mem_o = 1'b0;
            default: stall_mem_o = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            pend_rd    <= 1'b0;
            err_seen   <= 1'b0;
            data_mem_o <= '0;
            bus_err_o  <= 1'b0;
            err_addr_o <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                    err_seen <= 1'b0;
                    pend_rd  <= mem_rd_en_i & mem_wr_en_i;
                    if (mem_wr_en_i) begin
                        awaddr_q  <= addr_mem_wr_i;
                        wdata_q   <= data_mem_wr_i;
                        wstrb_q   <= strb_mem_wr_i;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state     <= S_WR;
                    end else if (mem_rd_en_i) begin
                        araddr_q  <= addr_mem_rd_i;
                        arvalid_q <= 1'b1;
                        state     <= S_RD_ADDR;
                    end
                end

                // AW and W may complete in either order or together.
                S_WR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        bready_q <= 1'b1;
                        state    <= S_WR_RESP;
                    end
                end

                S_WR_RESP: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        if (b_err) begin
                            err_seen   <= 1'b1;
                            err_addr_o <= awaddr_q;
                        end
                        if (pend_rd) begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= addr_mem_rd_i;
                            pend_rd   <= 1'b0;
                            state     <= S_RD_ADDR;
                        end else begin
                            bus_err_o <= err_seen | b_err;
                            state     <= S_DONE;
                        end
                    end
                end

                S_RD_ADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= S_RD_DATA;
                    end
                end

                // Read data is captured even on an error response.
                S_RD_DATA: begin
                    if (r_hs) begin
                        data_mem_o <= axi.m_rdata;
                        rready_q   <= 1'b0;
                        if (r_err) begin
                            err_addr_o <= araddr_q;
                        end
                        bus_err_o <= err_seen | r_err;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    bus_err_o <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CORE_MEM_BRIDGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_cnt_o    <= '0;
            perf_wr_cnt_o    <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (r_hs && perf_rd_cnt_o != '1) begin
                perf_rd_cnt_o <= perf_rd_cnt_o + 32'd1;
            end
            if (b_hs && perf_wr_cnt_o != '1) begin
                perf_wr_cnt_o <= perf_wr_cnt_o + 32'd1;
            end
            if (stall_mem_o && perf_stall_cnt_o != '1) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_mem_bridge.sv
// Directed bench for core_mem_bridge: a cycle-stepped AXI4-Lite slave plus a scoreboard of expected completions.
// Counter checks are included when CORE_MEM_BRIDGE_PERF_EN is defined.
module tb_core_mem_bridge;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr_rd;
    logic [ADDR_W-1:0] addr_wr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] data_mem;
    logic              stall;
    logic              bus_err;
    logic [ADDR_W-1:0] err_addr;
`ifdef CORE_MEM_BRIDGE_PERF_EN
    logic [31:0]       perf_rd;
    logic [31:0]       perf_wr;
    logic [31:0]       perf_stall;
`endif

    core_mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) axi ();

    core_mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_rd_en_i      (rd_en),
        .mem_wr_en_i      (wr_en),
        .addr_mem_rd_i    (addr_rd),
        .addr_mem_wr_i    (addr_wr),
        .data_mem_wr_i    (wdata),
        .strb_mem_wr_i    (wstrb),
        .data_mem_o       (data_mem),
        .stall_mem_o      (stall),
        .bus_err_o        (bus_err),
        .err_addr_o       (err_addr),
`ifdef CORE_MEM_BRIDGE_PERF_EN
        .perf_rd_cnt_o    (perf_rd),
        .perf_wr_cnt_o    (perf_wr),
        .perf_stall_cnt_o (perf_stall),
`endif
        .axi              (axi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic [63:0] eaddr;
        int          stall_cycles;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_data  = '0;
    logic [63:0] m_eaddr = '0;

    int          obs_aw, obs_w, obs_ar, obs_bready, b_cyc, ar_first;
    logic [63:0] obs_awaddr, obs_wdata, obs_araddr;
    logic [7:0]  obs_wstrb;

    task automatic push_exp(input logic [63:0] d, input logic e, input logic [63:0] ea, input int sc);
        exp_t x;
        x.data = d;
        x.err = e;
        x.eaddr = ea;
        x.stall_cycles = sc;
        exp_q.push_back(x);
    endtask

    task automatic slave_idle();
        axi.m_awready = 1'b0;
        axi.m_wready  = 1'b0;
        axi.m_bvalid  = 1'b0;
        axi.m_bresp   = 2'b00;
        axi.m_arready = 1'b0;
        axi.m_rvalid  = 1'b0;
        axi.m_rdata   = '0;
        axi.m_rresp   = 2'b00;
    endtask

    // Called on a falling edge; drives one request and steps the slave until the DONE cycle.
    task automatic run_txn(input logic rd, input logic wr, input logic [63:0] ard, input logic [63:0] awr,
                           input logic [63:0] wd, input logic [7:0] ws, input int aw_dly, input int w_dly,
                           input int ar_dly, input int r_dly, input logic [63:0] rdat,
                           input logic [1:0] rr, input logic [1:0] br);
        int   aw_c = 0, w_c = 0, ar_c = 0, r_c = 0, stall_c = 0, err_c = 0;
        bit   seen = 1'b0, done = 1'b0;
        exp_t e;
        obs_aw = 0; obs_w = 0; obs_ar = 0; obs_bready = 0; b_cyc = -1; ar_first = -1;
        rd_en = rd; wr_en = wr; addr_rd = ard; addr_wr = awr; wdata = wd; wstrb = ws;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (bus_err) err_c++;
            if (stall) begin
                stall_c++;
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
                check("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("data_mem", data_mem, e.data);
                    check("bus_err_done", bus_err, e.err);
                    check("err_addr", err_addr, e.eaddr);
                    check("stall_cycles", stall_c, e.stall_cycles);
                    check("bus_err_pulses", err_c, e.err ? 1 : 0);
                end
            end
            if (!done) begin
                if (axi.m_awvalid) begin obs_aw++; obs_awaddr = axi.m_awaddr; end
                if (axi.m_wvalid) begin obs_w++; obs_wdata = axi.m_wdata; obs_wstrb = axi.m_wstrb; end
                axi.m_awready = axi.m_awvalid && aw_c >= aw_dly;
                if (axi.m_awvalid) aw_c++;
                axi.m_wready = axi.m_wvalid && w_c >= w_dly;
                if (axi.m_wvalid) w_c++;
                axi.m_bvalid = axi.m_bready;
                axi.m_bresp  = axi.m_bready ? br : 2'b00;
                if (axi.m_bready) begin obs_bready++; b_cyc = cyc; end
                axi.m_arready = axi.m_arvalid && ar_c >= ar_dly;
                if (axi.m_arvalid) begin
                    ar_c++;
                    obs_ar++;
                    obs_araddr = axi.m_araddr;
                    if (ar_first < 0) ar_first = cyc;
                end
                axi.m_rvalid = axi.m_rready && r_c >= r_dly;
                axi.m_rdata  = axi.m_rvalid ? rdat : '0;
                axi.m_rresp  = axi.m_rvalid ? rr : 2'b00;
                if (axi.m_rready) r_c++;
                @(negedge clk);
            end
        end
        check("txn_completed", done, 1);
        rd_en = 1'b0;
        wr_en = 1'b0;
        slave_idle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rd_en = 1'b0; wr_en = 1'b0; addr_rd = '0; addr_wr = '0; wdata = '0; wstrb = '0;
        slave_idle();

        // Reset state
        #1;
        check("rst_stall", stall, 0);
        check("rst_awvalid", axi.m_awvalid, 0);
        check("rst_wvalid", axi.m_wvalid, 0);
        check("rst_arvalid", axi.m_arvalid, 0);
        check("rst_bready", axi.m_bready, 0);
        check("rst_rready", axi.m_rready, 0);
        check("rst_awaddr", axi.m_awaddr, 0);
        check("rst_data_mem", data_mem, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_bus_err", bus_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Read with rvalid two cycles after arvalid
        m_data = 64'h1122334455667788;
        push_exp(m_data, 1'b0, m_eaddr, 4);
        run_txn(1, 0, 64'h80001000, 0, 0, 0, 0, 0, 0, 1, 64'h1122334455667788, 2'b00, 2'b00);
        check("rd1_ar_cycles", obs_ar, 1);
        check("rd1_araddr", obs_araddr, 64'h80001000);

        // Write with AW delayed three cycles, W accepted at once
        push_exp(m_data, 1'b0, m_eaddr, 6);
        run_txn(0, 1, 0, 64'h80002008, 64'hDEADBEEF, 8'h0F, 3, 0, 0, 0, 0, 2'b00, 2'b00);
        check("wr1_aw_cycles", obs_aw, 4);
        check("wr1_w_cycles", obs_w, 1);
        check("wr1_bready_cycles", obs_bready, 1);
        check("wr1_awaddr", obs_awaddr, 64'h80002008);
        check("wr1_wdata", obs_wdata, 64'hDEADBEEF);
        check("wr1_wstrb", obs_wstrb, 8'h0F);

        // Write with W delayed, AW accepted at once
        push_exp(m_data, 1'b0, m_eaddr, 5);
        run_txn(0, 1, 0, 64'h700, 64'h0123456789ABCDEF, 8'hFF, 0, 2, 0, 0, 0, 2'b00, 2'b00);
        check("wr2_aw_cycles", obs_aw, 1);
        check("wr2_w_cycles", obs_w, 3);

        // Simultaneous write + read: read issued only after B
        m_data = 64'hA5A5000000000200;
        push_exp(m_data, 1'b0, m_eaddr, 5);
        run_txn(1, 1, 64'h200, 64'h100, 64'h55, 8'h01, 0, 0, 0, 0, 64'hA5A5000000000200, 2'b00, 2'b00);
        check("wr_rd_ar_after_b", ar_first > b_cyc, 1);
        check("wr_rd_araddr", obs_araddr, 64'h200);
        check("wr_rd_awaddr", obs_awaddr, 64'h100);
        check("wr_rd_ar_cycles", obs_ar, 1);

        // Read error: data still captured, error address recorded
        m_data  = 64'h0BAD;
        m_eaddr = 64'h300;
        push_exp(m_data, 1'b1, m_eaddr, 3);
        run_txn(1, 0, 64'h300, 0, 0, 0, 0, 0, 0, 0, 64'h0BAD, 2'b10, 2'b00);

        // Write and read both fail: read address wins
        m_data  = 64'hCAFE;
        m_eaddr = 64'h600;
        push_exp(m_data, 1'b1, m_eaddr, 5);
        run_txn(1, 1, 64'h600, 64'h500, 64'h1, 8'h01, 0, 0, 0, 0, 64'hCAFE, 2'b11, 2'b10);

        // Reset while waiting in RD_DATA
        rd_en = 1'b1;
        addr_rd = 64'h400;
        @(negedge clk);
        axi.m_arready = 1'b1;
        @(negedge clk);
        axi.m_arready = 1'b0;
        #1;
        check("pre_rst_rready", axi.m_rready, 1);
        #1;
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        check("mid_rst_rready", axi.m_rready, 0);
        check("mid_rst_arvalid", axi.m_arvalid, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_data_mem", data_mem, 0);
        check("mid_rst_err_addr", err_addr, 0);
        m_data  = '0;
        m_eaddr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two zero-wait reads and one zero-wait write after reset
        m_data = 64'h1111;
        push_exp(m_data, 1'b0, m_eaddr, 3);
        run_txn(1, 0, 64'h800, 0, 0, 0, 0, 0, 0, 0, 64'h1111, 2'b00, 2'b00);
        check("post_rst_araddr", obs_araddr, 64'h800);
        m_data = 64'h2222;
        push_exp(m_data, 1'b0, m_eaddr, 3);
        run_txn(1, 0, 64'h808, 0, 0, 0, 0, 0, 0, 0, 64'h2222, 2'b00, 2'b00);
        push_exp(m_data, 1'b0, m_eaddr, 3);
        run_txn(0, 1, 0, 64'h810, 64'h3333, 8'hF0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
`ifdef CORE_MEM_BRIDGE_PERF_EN
        check("perf_rd_cnt", perf_rd, 2);
        check("perf_wr_cnt", perf_wr, 1);
        check("perf_stall_cnt", perf_stall, 9);
`endif
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
